// File: rtl/fpu_pkg.sv
// Shared definitions for the FMUL front end: class bit positions, buffer state encoding
// and width helpers for packed/unpacked operand buses.
package fpu_pkg;

  localparam int CLS_ZERO   = 0;
  localparam int CLS_DENORM = 1;
  localparam int CLS_INF    = 2;
  localparam int CLS_NAN    = 3;
  localparam int CLS_W      = 4;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic int packed_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unpacked_w(input int exp_w, input int sig_w);
    return 1 + (exp_w + 1) + sig_w;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational classify-and-expand of one packed IEEE-754 operand into
// {sign, zero-extended exponent, hidden-bit significand}.
module fp_unpack
  import fpu_pkg::*;
#(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int SIG_W        = 32,
  parameter int FLUSH_DENORM = 1
) (
  input  logic [packed_w(EXP_W, MAN_W)-1:0]   op,
  output logic [unpacked_w(EXP_W, SIG_W)-1:0] unp,
  output logic [CLS_W-1:0]                    cls
);

  logic             sgn;
  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  logic [EXP_W:0]   exp_u;
  logic [SIG_W-1:0] sig_u;

  assign {sgn, e, m} = op;
  assign unp = {sgn, exp_u, sig_u};

  always_comb begin
    cls            = '0;
    exp_u          = {1'b0, e};
    sig_u          = '0;
    sig_u[MAN_W:0] = {1'b1, m};
    if (e == '0) begin
      exp_u = '0;
      sig_u = '0;
      if (m == '0) begin
        cls[CLS_ZERO] = 1'b1;
      end else if (FLUSH_DENORM != 0) begin
        cls[CLS_ZERO]   = 1'b1;
        cls[CLS_DENORM] = 1'b1;
      end else begin
        // Denormal kept: effective exponent 1, no hidden bit.
        cls[CLS_DENORM]    = 1'b1;
        exp_u              = {{EXP_W{1'b0}}, 1'b1};
        sig_u[MAN_W-1:0]   = m;
      end
    end else if (e == '1) begin
      if (m == '0) cls[CLS_INF] = 1'b1;
      else         cls[CLS_NAN] = 1'b1;
    end
  end

endmodule

// File: rtl/fmul_unpack_stage.sv
// FMUL operand-unpack stage: unpacks both operands and queues them in a 2-entry
// skid buffer so downstream backpressure never drops or duplicates an operation.
//
//   state    | meaning
//   ST_EMPTY | no entry; in_ready=1, out_valid=0
//   ST_ONE   | head valid; in_ready=1
//   ST_TWO   | head + skid valid; in_ready=0
module fmul_unpack_stage
  import fpu_pkg::*;
#(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int SIG_W        = 32,
  parameter int TAG_W        = 4,
  parameter int FLUSH_DENORM = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [packed_w(EXP_W, MAN_W)-1:0]   in_a,
  input  logic [packed_w(EXP_W, MAN_W)-1:0]   in_b,
  input  logic [TAG_W-1:0]                    in_tag,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [unpacked_w(EXP_W, SIG_W)-1:0] out_x,
  output logic [unpacked_w(EXP_W, SIG_W)-1:0] out_y,
  output logic [CLS_W-1:0]                    out_xcls,
  output logic [CLS_W-1:0]                    out_ycls,
  output logic [TAG_W-1:0]                    out_tag,
  output logic [1:0]                          out_count
);

  localparam int UW    = unpacked_w(EXP_W, SIG_W);
  localparam int ENT_W = 2 * UW + 2 * CLS_W + TAG_W;

  logic [UW-1:0]    x_u, y_u;
  logic [CLS_W-1:0] xcls_u, ycls_u;
  logic [ENT_W-1:0] new_ent, head_q, skid_q;
  state_t           state;
  logic             in_ready_q;
  logic             push, pop;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SIG_W(SIG_W), .FLUSH_DENORM(FLUSH_DENORM))
    u_unpack_a (.op(in_a), .unp(x_u), .cls(xcls_u));

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SIG_W(SIG_W), .FLUSH_DENORM(FLUSH_DENORM))
    u_unpack_b (.op(in_b), .unp(y_u), .cls(ycls_u));

  assign new_ent   = {x_u, y_u, xcls_u, ycls_u, in_tag};
  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign out_count = state;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign {out_x, out_y, out_xcls, out_ycls, out_tag} = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head_q <= new_ent;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            skid_q     <= new_ent;
            state      <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (push && pop) begin
            head_q <= new_ent;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Older entry sits in head, so the skid entry is next in line.
          if (pop) begin
            head_q     <= skid_q;
            state      <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
